bullet_engine: RTL

Owns the bullet pool for both tanks: allocates slots on fire requests, advances every live bullet once per video frame, and retires bullets on expiry or screen exit. Its registered `bullet_array` is the exact word array the drawing engine scans per pixel, so this block is the writer end of that interface. It sits in the motion engine beside the tank position logic, clocked in the system clock domain.

---
 rtl/tank_pkg.sv | 51 +++++
 rtl/bullet_step.sv | 91 +++++++++
 rtl/bullet_engine.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/tank_pkg.sv
// Shared types for the tank motion engine: slot word layout, directions, FSM states.
// Also provides the per-direction unit step helpers.
package tank_pkg;

    localparam int SCREEN_W  = 640;
    localparam int SCREEN_H  = 480;
    localparam int SPAWN_OFS = 14;

    typedef enum logic [2:0] {
        DIR_UP = 3'd0,
        DIR_UR = 3'd1,
        DIR_R  = 3'd2,
        DIR_DR = 3'd3,
        DIR_DN = 3'd4,
        DIR_DL = 3'd5,
        DIR_L  = 3'd6,
        DIR_UL = 3'd7
    } dir_e;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_UPDATE = 1'b1
    } state_e;

    typedef struct packed {
        logic [2:0] pad;
        logic [9:0] y;
        logic [9:0] x;
        logic [4:0] life;
        dir_e       dir;
        logic       valid;
    } bullet_t;

    // Unit step encoding: 2'b01 = +1, 2'b11 = -1, 2'b00 = 0.
    function automatic logic [1:0] dir_dx(input dir_e d);
        case (d)
            DIR_UR, DIR_R, DIR_DR: dir_dx = 2'b01;
            DIR_DL, DIR_L, DIR_UL: dir_dx = 2'b11;
            default:               dir_dx = 2'b00;
        endcase
    endfunction

    function automatic logic [1:0] dir_dy(input dir_e d);
        case (d)
            DIR_UP, DIR_UR, DIR_UL: dir_dy = 2'b11;
            DIR_DR, DIR_DN, DIR_DL: dir_dy = 2'b01;
            default:                dir_dy = 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/bullet_step.sv
// One-frame advance of a single bullet slot: life countdown, motion, and screen bounds.
// Optional macro BULLET_WALL_BOUNCE_EN reflects bullets off the screen edges instead of retiring them.
module bullet_step
    import tank_pkg::*;
#(
    parameter int SPEED = 4
) (
    input  bullet_t cur_i,
    output bullet_t nxt_o
);

    localparam logic signed [10:0] STEP  = 11'(SPEED);
    localparam logic signed [10:0] X_MAX = 11'(SCREEN_W - 1);
    localparam logic signed [10:0] Y_MAX = 11'(SCREEN_H - 1);

    logic [1:0]         dx_s;
    logic [1:0]         dy_s;
    logic [4:0]         life_s;
    logic signed [10:0] x_s;
    logic signed [10:0] y_s;
    logic signed [10:0] nx_s;
    logic signed [10:0] ny_s;
    logic               x_out_s;
    logic               y_out_s;

    // Candidate position and life for this frame, in 11-bit signed space.
    always_comb begin
        dx_s   = dir_dx(cur_i.dir);
        dy_s   = dir_dy(cur_i.dir);
        life_s = cur_i.life - 5'd1;
        x_s    = $signed({1'b0, cur_i.x});
        y_s    = $signed({1'b0, cur_i.y});
        case (dx_s)
            2'b01:   nx_s = x_s + STEP;
            2'b11:   nx_s = x_s - STEP;
            default: nx_s = x_s;
        endcase
        case (dy_s)
            2'b01:   ny_s = y_s + STEP;
            2'b11:   ny_s = y_s - STEP;
            default: ny_s = y_s;
        endcase
        x_out_s = (nx_s < 11'sd0) || (nx_s > X_MAX);
        y_out_s = (ny_s < 11'sd0) || (ny_s > Y_MAX);
    end

`ifdef BULLET_WALL_BOUNCE_EN
    logic [2:0] bdir_s;

    // Expiry retires; edge hits clamp the coordinate and mirror the heading.
    always_comb begin
        nxt_o  = cur_i;
        bdir_s = cur_i.dir;
        if (!cur_i.valid) begin
            nxt_o = cur_i;
        end else if (life_s == 5'd0) begin
            nxt_o = '0;
        end else begin
            nxt_o.life = life_s;
            if (x_out_s) begin
                nxt_o.x = (nx_s < 11'sd0) ? 10'd0 : X_MAX[9:0];
                bdir_s  = 3'd0 - bdir_s;
            end else begin
                nxt_o.x = nx_s[9:0];
            end
            if (y_out_s) begin
                nxt_o.y = (ny_s < 11'sd0) ? 10'd0 : Y_MAX[9:0];
                bdir_s  = 3'd4 - bdir_s;
            end else begin
                nxt_o.y = ny_s[9:0];
            end
            nxt_o.dir = dir_e'(bdir_s);
        end
    end
`else
    // Expiry or leaving the screen retires the slot.
    always_comb begin
        nxt_o = cur_i;
        if (!cur_i.valid) begin
            nxt_o = cur_i;
        end else if ((life_s == 5'd0) || x_out_s || y_out_s) begin
            nxt_o = '0;
        end else begin
            nxt_o.x    = nx_s[9:0];
            nxt_o.y    = ny_s[9:0];
            nxt_o.life = life_s;
        end
    end
`endif

endmodule

// File: rtl/bullet_engine.sv
// Bullet pool owner: allocates slots on fire requests and walks all slots once per frame.
// BULLET_WALL_BOUNCE_EN (see bullet_step) selects wall bounce instead of retirement.
module bullet_engine
    import tank_pkg::*;
#(
    parameter int ARRAY_SIZE = 8,
    parameter int TANK_NUM   = 2,
    parameter int SPEED      = 4,
    parameter int LIFETIME   = 31
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic        frame_tick,
    input  logic [9:0]  tank_x       [TANK_NUM],
    input  logic [9:0]  tank_y       [TANK_NUM],
    input  logic        fire_req     [TANK_NUM],
    input  logic [2:0]  fire_dir     [TANK_NUM],
    output logic        fire_ack     [TANK_NUM],
    output logic        fire_drop    [TANK_NUM],
    output logic        busy,
    output logic [31:0] bullet_array [TANK_NUM][ARRAY_SIZE]
);

    localparam int SLOT_W = $clog2(ARRAY_SIZE);
    localparam int TANK_W = $clog2(TANK_NUM);
    localparam int K_W    = SLOT_W + TANK_W;
    localparam logic [K_W-1:0] K_LAST = K_W'(TANK_NUM * ARRAY_SIZE - 1);

    state_e                state_q, state_d;
    logic [K_W-1:0]        k_q, k_d;
    logic [TANK_NUM-1:0]   armed_q, armed_d;
    logic [TANK_NUM-1:0]   ack_q, ack_d;
    logic [TANK_NUM-1:0]   drop_q, drop_d;
    logic                  busy_q, busy_d;
    bullet_t               arr_q [TANK_NUM][ARRAY_SIZE];
    bullet_t               arr_d [TANK_NUM][ARRAY_SIZE];

    logic                  free_ok_s  [TANK_NUM];
    logic [SLOT_W-1:0]     free_idx_s [TANK_NUM];
    logic [TANK_W-1:0]     k_tank_s;
    logic [SLOT_W-1:0]     k_slot_s;
    bullet_t               step_cur_s;
    bullet_t               step_nxt_s;

    assign k_tank_s   = k_q[K_W-1:SLOT_W];
    assign k_slot_s   = k_q[SLOT_W-1:0];
    assign step_cur_s = arr_q[k_tank_s][k_slot_s];

    bullet_step #(
        .SPEED (SPEED)
    ) u_step (
        .cur_i (step_cur_s),
        .nxt_o (step_nxt_s)
    );

    // Lowest free slot per tank; scanning downward lets the lowest index win.
    always_comb begin
        for (int t = 0; t < TANK_NUM; t++) begin
            free_ok_s[t]  = 1'b0;
            free_idx_s[t] = '0;
            for (int s = ARRAY_SIZE - 1; s >= 0; s--) begin
                free_ok_s[t]  = arr_q[t][s].valid ? free_ok_s[t]  : 1'b1;
                free_idx_s[t] = arr_q[t][s].valid ? free_idx_s[t] : SLOT_W'(s);
            end
        end
    end

    // FSM state register.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state: a tick starts the slot walk, the last slot ends it.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (frame_tick) state_d = ST_UPDATE;
                else            state_d = ST_IDLE;
            end
            ST_UPDATE: begin
                if (k_q == K_LAST) state_d = ST_IDLE;
                else               state_d = ST_UPDATE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM outputs: fire service in IDLE, one slot advanced per cycle in UPDATE.
    always_comb begin
        logic    served_v;
        bullet_t spawn_v;
        arr_d    = arr_q;
        k_d      = '0;
        ack_d    = '0;
        drop_d   = '0;
        busy_d   = (state_d == ST_UPDATE);
        served_v = 1'b0;
        spawn_v  = '0;
        // A served requester must drop its request before it can be served again.
        for (int t = 0; t < TANK_NUM; t++) begin
            armed_d[t] = armed_q[t] | ~fire_req[t];
        end
        case (state_q)
            ST_IDLE: begin
                if (!frame_tick) begin
                    for (int t = 0; t < TANK_NUM; t++) begin
                        if (!served_v && fire_req[t] && armed_q[t]) begin
                            served_v   = 1'b1;
                            armed_d[t] = 1'b0;
                            spawn_v       = '0;
                            spawn_v.valid = 1'b1;
                            spawn_v.dir   = dir_e'(fire_dir[t]);
                            spawn_v.life  = 5'(LIFETIME);
                            spawn_v.x     = tank_x[t] + 10'(SPAWN_OFS);
                            spawn_v.y     = tank_y[t] + 10'(SPAWN_OFS);
                            if (free_ok_s[t]) begin
                                arr_d[t][free_idx_s[t]] = spawn_v;
                                ack_d[t] = 1'b1;
                            end else begin
                                drop_d[t] = 1'b1;
                            end
                        end else begin
                            served_v = served_v;
                        end
                    end
                end else begin
                    k_d = '0;
                end
            end
            ST_UPDATE: begin
                arr_d[k_tank_s][k_slot_s] = step_nxt_s;
                if (k_q == K_LAST) k_d = '0;
                else               k_d = k_q + K_W'(1);
            end
            default: begin
                k_d = '0;
            end
        endcase
    end

    // Datapath registers: slot array, walk counter, handshake pulses.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            k_q     <= '0;
            armed_q <= '1;
            ack_q   <= '0;
            drop_q  <= '0;
            busy_q  <= 1'b0;
            for (int t = 0; t < TANK_NUM; t++) begin
                for (int s = 0; s < ARRAY_SIZE; s++) begin
                    arr_q[t][s] <= '0;
                end
            end
        end else begin
            k_q     <= k_d;
            armed_q <= armed_d;
            ack_q   <= ack_d;
            drop_q  <= drop_d;
            busy_q  <= busy_d;
            arr_q   <= arr_d;
        end
    end

    // Output ports straight from registers.
    always_comb begin
        busy = busy_q;
        for (int t = 0; t < TANK_NUM; t++) begin
            fire_ack[t]  = ack_q[t];
            fire_drop[t] = drop_q[t];
            for (int s = 0; s < ARRAY_SIZE; s++) begin
                bullet_array[t][s] = arr_q[t][s];
            end
        end
    end

endmodule
